move_sequencer: RTL
===================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter LOCK_TICKS, 2: number of blocked gravity ticks before a piece locks; range 1-15.
REQ-002 Parameter SETTLE_CYCLES, 2: wait cycles after a move pulse so the per-direction enables re-evaluate; range 1-15.
REQ-003 Parameter REPEAT_CYCLES, 10_000_000: auto-repeat period for a held left/right button.
REQ-004 Port clk  input  1: single clock; all state on rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port start  input  1: one-cycle pulse that begins play.
REQ-007 Port tick  input  1: one-cycle gravity pulse.
REQ-008 Ports btn_up, btn_left, btn_right  input  1 each: debounced levels (up = rotate/raise request).
REQ-009 Ports up_en, down_en, left_en, right_en  input  1 each: combined move-enables for the whole piece; 1 = move legal.
REQ-010 Port spawn_ack  input  1: new piece placed.
REQ-011 Ports move_up, move_down, move_left, move_right  output  1 each: one-cycle move commands.
REQ-012 Port spawn_req  output  1: level, held until spawn_ack.
REQ-013 Port lock  output  1: one-cycle pulse when a piece is fixed.
REQ-014 Port busy  output  1: high in every state except IDLE and READY.

Function
REQ-015 States SHALL be IDLE, SPAWN, READY, SETTLE and LOCK.
REQ-016 IDLE -> SPAWN on start; all other inputs ignored in IDLE.
REQ-017 SPAWN asserts spawn_req; on spawn_ack: deassert in the same cycle as the transition to READY, clear lock count and all button-pending flags.
REQ-018 Rising edges of btn_* and tick SHALL set sticky pending flags in any non-IDLE state; no event is lost to simultaneity.
REQ-019 READY services at most one pending event per cycle; priority tick > left > right > up; the serviced flag clears.
REQ-020 Serviced event with its enable = 1: corresponding move_* pulses for exactly one cycle (registered, one cycle after selection), then SETTLE.
REQ-021 Serviced left/right/up with enable = 0: event dropped, no pulse, remain READY.
REQ-022 Serviced tick with down_en = 0: lock count increments; reaching LOCK_TICKS -> LOCK, otherwise remain READY.
REQ-023 Every issued move_down SHALL clear the lock count.
REQ-024 SETTLE lasts exactly SETTLE_CYCLES cycles, then READY.
REQ-025 LOCK pulses lock for one cycle, then SPAWN; a pending tick survives into the next piece.
REQ-026 At most one move_* output is high in any cycle.

Reset
REQ-027 rst_n low: state IDLE; all outputs, pending flags, lock, settle and repeat counters 0, immediately and asynchronously.
REQ-028 Reset mid-SETTLE or mid-SPAWN SHALL abandon the operation with no further pulses after release.

Configuration
REQ-029 With AUTOREPEAT_EN defined, a left/right button held continuously re-sets its pending flag every REPEAT_CYCLES cycles after the initial edge; the counter restarts on release or direction change.
REQ-030 Without AUTOREPEAT_EN, only rising edges generate events and no repeat counter exists.

Structure
REQ-031 A shared package SHALL hold the state enum typedef, the direction encoding typedef and the default parameter constants.
REQ-032 One sub-module, edge_pending, SHALL implement the edge detector plus sticky pending flag (with the optional repeat counter), instantiated once per event source.

Verification
REQ-033 start, spawn_ack after 3 cycles -> spawn_req high 3 cycles, busy low, state READY.
REQ-034 Tick with down_en=1 -> move_down one-cycle pulse, busy high for SETTLE_CYCLES=2 cycles, then READY.
REQ-035 tick and btn_left rise in same cycle, all enables 1 -> move_down first, move_left after settle; no overlap.
REQ-036 down_en=0, two ticks with LOCK_TICKS=2 -> no move_down, lock pulse after second tick, spawn_req reasserts next cycle.
REQ-037 left_en=0, btn_left rise -> no pulse, flag cleared, subsequent tick still serviced.
REQ-038 AUTOREPEAT_EN, REPEAT_CYCLES=8, btn_right held 30 cycles, right_en=1 -> move_right pulses at edge+1 then every 8 cycles (4 total).

Source files
------------

// File: rtl/move_sequencer_pkg.sv
// Shared types and defaults for the move sequencer: FSM states, move directions
// and the parameter defaults used by the top and the edge_pending sub-module.
package move_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        READY,
        SETTLE,
        LOCK
    } state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT,
        DIR_UP
    } dir_t;

    localparam int DEF_LOCK_TICKS    = 2;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_REPEAT_CYCLES = 10_000_000;
    localparam int CNT_W             = 4;

    // Bit position of a direction in the {up, right, left, down} move/enable vectors.
    function automatic logic [1:0] dir_bit(input dir_t d);
        case (d)
            DIR_LEFT:  dir_bit = 2'd1;
            DIR_RIGHT: dir_bit = 2'd2;
            DIR_UP:    dir_bit = 2'd3;
            default:   dir_bit = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/move_sequencer_edge_pending.sv
// Rising-edge detector feeding a sticky pending flag; a new event wins over a clear.
// With AUTOREPEAT_EN defined, REPEAT_EN instances re-arm the flag while the input is held.
module edge_pending
    import move_sequencer_pkg::*;
#(
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic level_i,
    input  logic clr_i,
    output logic pending_o
);

    logic level_q;
    logic pending_q;
    logic pending_d;
    logic rise;
    logic set_evt;

    assign rise      = level_i & ~level_q;
    assign pending_o = pending_q;

    always_comb begin
        pending_d = pending_q;
        if (set_evt) begin
            pending_d = 1'b1;
        end else if (clr_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            level_q   <= level_i;
            pending_q <= pending_d;
        end
    end

`ifdef AUTOREPEAT_EN
    if (REPEAT_EN) begin : g_repeat
        localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
        logic [RPT_W-1:0] rpt_q;
        logic [RPT_W-1:0] rpt_d;
        logic             held;
        logic             rpt_hit;

        // Counter restarts on the initial edge and on release.
        assign held    = en_i & level_i & level_q;
        assign rpt_hit = held & (rpt_q == RPT_W'(REPEAT_CYCLES - 1));
        assign set_evt = en_i & (rise | rpt_hit);

        always_comb begin
            rpt_d = '0;
            if (held && !rpt_hit) begin
                rpt_d = rpt_q + RPT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rpt_q <= '0;
            end else begin
                rpt_q <= rpt_d;
            end
        end
    end else begin : g_plain
        assign set_evt = en_i & rise;
    end
`else
    assign set_evt = en_i & rise;
`endif

endmodule

// File: rtl/move_sequencer.sv
// Piece move sequencer: turns gravity ticks and button edges into one-cycle move
// commands, handles lock-out and respawn. AUTOREPEAT_EN enables held left/right repeat.
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int LOCK_TICKS    = DEF_LOCK_TICKS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic tick,
    input  logic btn_up,
    input  logic btn_left,
    input  logic btn_right,
    input  logic up_en,
    input  logic down_en,
    input  logic left_en,
    input  logic right_en,
    input  logic spawn_ack,
    output logic move_up,
    output logic move_down,
    output logic move_left,
    output logic move_right,
    output logic spawn_req,
    output logic lock,
    output logic busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [3:0]       move_q, move_d;
    logic [3:0]       src, pend, svc, clr, en_vec;
    logic             active, flush;
    dir_t             sel;
    logic [1:0]       sel_bit;

    // Vectors ordered {up, right, left, down}; bit 0 is the gravity tick.
    assign src    = {btn_up, btn_right, btn_left, tick};
    assign en_vec = {up_en, right_en, left_en, down_en};
    assign active = (state_q != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_src
            // The tick flag is not flushed on spawn so it carries into the next piece.
            assign clr[gi] = svc[gi] | (flush & (gi != 0));
            edge_pending #(
                .REPEAT_EN     ((gi == 1) || (gi == 2)),
                .REPEAT_CYCLES (REPEAT_CYCLES)
            ) u_pend (
                .clk       (clk),
                .rst_n     (rst_n),
                .en_i      (active),
                .level_i   (src[gi]),
                .clr_i     (clr[gi]),
                .pending_o (pend[gi])
            );
        end
    endgenerate

    always_comb begin
        sel = DIR_NONE;
        if (pend[0]) begin
            sel = DIR_DOWN;
        end else if (pend[1]) begin
            sel = DIR_LEFT;
        end else if (pend[2]) begin
            sel = DIR_RIGHT;
        end else if (pend[3]) begin
            sel = DIR_UP;
        end
    end

    assign sel_bit = dir_bit(sel);

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        settle_cnt_d = settle_cnt_q;
        move_d       = '0;
        svc          = '0;
        flush        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SPAWN;
            end
            SPAWN: begin
                if (spawn_ack) begin
                    state_d    = READY;
                    lock_cnt_d = '0;
                    flush      = 1'b1;
                end
            end
            READY: begin
                if (sel != DIR_NONE) begin
                    svc[sel_bit] = 1'b1;
                    if (en_vec[sel_bit]) begin
                        move_d[sel_bit] = 1'b1;
                        settle_cnt_d    = '0;
                        state_d         = SETTLE;
                        if (sel == DIR_DOWN) lock_cnt_d = '0;
                    end else if (sel == DIR_DOWN) begin
                        lock_cnt_d = lock_cnt_q + CNT_W'(1);
                        if (lock_cnt_q == CNT_W'(LOCK_TICKS - 1)) state_d = LOCK;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = READY;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end
            LOCK: begin
                state_d = SPAWN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            move_q       <= '0;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            move_q       <= move_d;
        end
    end

    assign move_down  = move_q[0];
    assign move_left  = move_q[1];
    assign move_right = move_q[2];
    assign move_up    = move_q[3];
    assign spawn_req  = (state_q == SPAWN);
    assign lock       = (state_q == LOCK);
    assign busy       = (state_q != IDLE) && (state_q != READY);

endmodule
